// File: rtl/ahb_slave_if_pkg.sv
// Shared definitions for the AHB-to-APB bridge: AHB encodings, error FSM
// state encoding and default address map parameters.
package ahb_slave_if_pkg;

    localparam logic [1:0] HTRANS_IDLE   = 2'b00;
    localparam logic [1:0] HTRANS_BUSY   = 2'b01;
    localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
    localparam logic [1:0] HTRANS_SEQ    = 2'b11;

    localparam logic [1:0] HRESP_OKAY  = 2'b00;
    localparam logic [1:0] HRESP_ERROR = 2'b01;

    localparam logic [31:0] DEFAULT_BASE_ADDR = 32'h8000_0000;
    localparam int          DEFAULT_SLOT_BITS = 26;

    // Two-cycle AHB error response sequencer
    typedef enum logic [1:0] {
        ERR_IDLE   = 2'b00,
        ERR_FIRST  = 2'b01,
        ERR_SECOND = 2'b10
    } err_state_e;

    // An address phase is live only when the bus is ready and the transfer
    // is NONSEQ or SEQ (bit 1 of Htrans set); IDLE and BUSY never are.
    function automatic logic is_active(input logic hreadyin, input logic htrans_hi);
        return hreadyin & htrans_hi;
    endfunction

endpackage

// File: rtl/ahb_slave_if_if.sv
// AHB-side bus bundle of the bridge slave front end. The slave modport is
// the bridge view, the master modport is the AHB master / bench view.
interface ahb_slave_if_if;

    logic        Hwrite;
    logic        Hreadyin;
    logic [1:0]  Htrans;
    logic [2:0]  Hsize;
    logic [31:0] Haddr;
    logic [31:0] Hwdata;
    logic [31:0] Prdata;

    logic        valid;
    logic [31:0] Haddr1;
    logic [31:0] Haddr2;
    logic [31:0] Hwdata1;
    logic [31:0] Hwdata2;
    logic        Hwritereg;
    logic [2:0]  tempselx;
    logic [31:0] Hrdata;
    logic [1:0]  Hresp;
    logic        Herr_stall;

    modport slave (
        input  Hwrite, Hreadyin, Htrans, Hsize, Haddr, Hwdata, Prdata,
        output valid, Haddr1, Haddr2, Hwdata1, Hwdata2, Hwritereg,
               tempselx, Hrdata, Hresp, Herr_stall
    );

    modport master (
        output Hwrite, Hreadyin, Htrans, Hsize, Haddr, Hwdata, Prdata,
        input  valid, Haddr1, Haddr2, Hwdata1, Hwdata2, Hwritereg,
               tempselx, Hrdata, Hresp, Herr_stall
    );

endinterface

// File: rtl/ahb_slave_if_addr_decode.sv
// Combinational address decoder: peripheral one-hot select, unmapped flag
// and size/alignment check. Pure bit compares, no address arithmetic.
module ahb_addr_decode
    import ahb_slave_if_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR = DEFAULT_BASE_ADDR,
    parameter int          SLOT_BITS = DEFAULT_SLOT_BITS
) (
    input  logic [31:0] Haddr,
    input  logic [2:0]  Hsize,
    output logic [2:0]  tempselx,
    output logic        unmapped,
    output logic        misaligned
);

    logic       in_win_s;
    logic [1:0] slot_s;
    logic       unused_offset_s;

    // Offset bits inside a slot play no part in decode.
    assign unused_offset_s = ^Haddr[SLOT_BITS-1:2];

    // Window match and slot-to-select decode; slot 3 is a hole in the map
    always_comb begin
        in_win_s = (Haddr[31:SLOT_BITS+2] == BASE_ADDR[31:SLOT_BITS+2]);
        slot_s   = Haddr[SLOT_BITS+1:SLOT_BITS];
        tempselx = 3'b000;
        if (in_win_s) begin
            case (slot_s)
                2'b00:   tempselx = 3'b001;
                2'b01:   tempselx = 3'b010;
                2'b10:   tempselx = 3'b100;
                default: tempselx = 3'b000;
            endcase
        end else begin
            tempselx = 3'b000;
        end
        unmapped = (tempselx == 3'b000);
    end

    // Natural alignment check; sizes above word are never supported
    always_comb begin
        misaligned = 1'b0;
        case (Hsize)
            3'b000:  misaligned = 1'b0;
            3'b001:  misaligned = Haddr[0];
            3'b010:  misaligned = (Haddr[1:0] != 2'b00);
            default: misaligned = 1'b1;
        endcase
    end

endmodule

// File: rtl/ahb_slave_if.sv
// AHB-Lite slave front end of the AHB-to-APB bridge: address/data pipeline,
// transfer qualification and the two-cycle ERROR response sequencer.
module ahb_slave_if
    import ahb_slave_if_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR = DEFAULT_BASE_ADDR,
    parameter int          SLOT_BITS = DEFAULT_SLOT_BITS
) (
    input  logic         Hclk,
    input  logic         Hresetn,
    ahb_slave_if_if.slave bus
);

    logic [31:0] haddr1_r;
    logic [31:0] haddr2_r;
    logic [31:0] hwdata1_r;
    logic [31:0] hwdata2_r;
    logic        hwritereg_r;

    err_state_e  state_r;
    err_state_e  state_next_s;

    logic [2:0]  tempselx_s;
    logic        unmapped_s;
    logic        misaligned_s;
    logic        active_s;
    logic        err_access_s;
    logic [1:0]  hresp_s;
    logic        herr_stall_s;
    logic        unused_trans_s;

    ahb_addr_decode #(
        .BASE_ADDR (BASE_ADDR),
        .SLOT_BITS (SLOT_BITS)
    ) u_decode (
        .Haddr      (bus.Haddr),
        .Hsize      (bus.Hsize),
        .tempselx   (tempselx_s),
        .unmapped   (unmapped_s),
        .misaligned (misaligned_s)
    );

    // Htrans[0] only separates NONSEQ from SEQ, which this block treats alike.
    assign unused_trans_s = bus.Htrans[0];

    // Transfer qualification: errored accesses and anything seen while an
    // error response is in flight never reach the APB controller
    always_comb begin
        active_s     = is_active(bus.Hreadyin, bus.Htrans[1]);
        err_access_s = active_s & (unmapped_s | misaligned_s);
        if (state_r == ERR_IDLE) begin
            bus.valid = active_s & ~err_access_s;
        end else begin
            bus.valid = 1'b0;
        end
    end

    // Address/data/direction pipeline, advancing only on accepted cycles
    always_ff @(posedge Hclk) begin
        if (!Hresetn) begin
            haddr1_r    <= 32'h0000_0000;
            haddr2_r    <= 32'h0000_0000;
            hwdata1_r   <= 32'h0000_0000;
            hwdata2_r   <= 32'h0000_0000;
            hwritereg_r <= 1'b0;
        end else if (bus.Hreadyin) begin
            haddr1_r    <= bus.Haddr;
            haddr2_r    <= haddr1_r;
            hwdata1_r   <= bus.Hwdata;
            hwdata2_r   <= hwdata1_r;
            hwritereg_r <= bus.Hwrite;
        end else begin
            haddr1_r    <= haddr1_r;
            haddr2_r    <= haddr2_r;
            hwdata1_r   <= hwdata1_r;
            hwdata2_r   <= hwdata2_r;
            hwritereg_r <= hwritereg_r;
        end
    end

    // Error FSM state register
    always_ff @(posedge Hclk) begin
        if (!Hresetn) begin
            state_r <= ERR_IDLE;
        end else begin
            state_r <= state_next_s;
        end
    end

    // Error FSM next state: FIRST always leads to SECOND; SECOND may chain
    // straight into another response when a new error access arrives
    always_comb begin
        state_next_s = ERR_IDLE;
        case (state_r)
            ERR_IDLE: begin
                if (err_access_s) begin
                    state_next_s = ERR_FIRST;
                end else begin
                    state_next_s = ERR_IDLE;
                end
            end
            ERR_FIRST: begin
                state_next_s = ERR_SECOND;
            end
            ERR_SECOND: begin
                if (err_access_s) begin
                    state_next_s = ERR_FIRST;
                end else begin
                    state_next_s = ERR_IDLE;
                end
            end
            default: begin
                state_next_s = ERR_IDLE;
            end
        endcase
    end

    // Error FSM outputs: ERROR on both response cycles, stall only on the first
    always_comb begin
        hresp_s      = HRESP_OKAY;
        herr_stall_s = 1'b0;
        case (state_r)
            ERR_IDLE: begin
                hresp_s      = HRESP_OKAY;
                herr_stall_s = 1'b0;
            end
            ERR_FIRST: begin
                hresp_s      = HRESP_ERROR;
                herr_stall_s = 1'b1;
            end
            ERR_SECOND: begin
                hresp_s      = HRESP_ERROR;
                herr_stall_s = 1'b0;
            end
            default: begin
                hresp_s      = HRESP_OKAY;
                herr_stall_s = 1'b0;
            end
        endcase
    end

    assign bus.tempselx   = tempselx_s;
    assign bus.Hrdata     = bus.Prdata;
    assign bus.Haddr1     = haddr1_r;
    assign bus.Haddr2     = haddr2_r;
    assign bus.Hwdata1    = hwdata1_r;
    assign bus.Hwdata2    = hwdata2_r;
    assign bus.Hwritereg  = hwritereg_r;
    assign bus.Hresp      = hresp_s;
    assign bus.Herr_stall = herr_stall_s;

endmodule

// File: doc/ahb_slave_if.md
# ahb_slave_if

AHB-Lite slave front end of the AHB-to-APB bridge. It sits directly upstream of the APB controller and owns all address-phase work:
- pipelines AHB address, write data and direction into `Haddr1/Haddr2`, `Hwdata1/Hwdata2` and `Hwritereg`;
- decodes the peripheral select `tempselx`;
- qualifies transfers into `valid`;
- generates the two-cycle AHB ERROR response for unmapped or misaligned accesses.

Read data from APB passes straight back to the AHB master.

## Interface
Parameters:
- BASE_ADDR, 32'h8000_0000, base of the APB window
- SLOT_BITS, 26, log2 of bytes per peripheral slot (64 MB)

Ports:
- Hclk  in  1  bridge clock; all state on rising edge
- Hresetn  in  1  reset; one clock; reset is synchronous and active-low
- Hwrite  in  1  AHB direction, 1 = write
- Hreadyin  in  1  AHB bus ready (address phase accepted when 1)
- Htrans  in  2  AHB transfer type: IDLE=00, BUSY=01, NONSEQ=10, SEQ=11
- Hsize  in  3  AHB size: 000 byte, 001 half, 010 word
- Haddr  in  32  AHB address
- Hwdata  in  32  AHB write data
- Prdata  in  32  APB read data
- valid  out  1  qualified transfer to the APB controller, combinational
- Haddr1, Haddr2  out  32  address delayed 1 / 2 accepted cycles
- Hwdata1, Hwdata2  out  32  write data delayed 1 / 2 accepted cycles
- Hwritereg  out  1  Hwrite delayed 1 accepted cycle
- tempselx  out  3  one-hot peripheral select, combinational
- Hrdata  out  32  equals Prdata, combinational
- Hresp  out  2  00 OKAY, 01 ERROR
- Herr_stall  out  1  1 = drive Hreadyout low (ORed with the controller's stall at top level)

## Operation
- **Active transfer:** Hreadyin=1 and Htrans[1]=1 (NONSEQ or SEQ). IDLE and BUSY are never active.
- **Window and slot:**
  - `in_win` = Haddr[31:SLOT_BITS+2] equals BASE_ADDR[31:SLOT_BITS+2].
  - `slot` = Haddr[SLOT_BITS+1:SLOT_BITS].
- **Select decode:**
  - slot 0 → 001, slot 1 → 010, slot 2 → 100.
  - Slot 3, or `in_win`=0, → 000 (unmapped).
- **Misaligned:** Hsize=001 with Haddr[0]=1; Hsize=010 with Haddr[1:0]≠0; Hsize>010 always.
- **Error access:** active, and (unmapped or misaligned).
- **valid:** active and not error access and FSM in ERR_IDLE.
- **Pipeline:** when Hreadyin=1:
  - Haddr1←Haddr, Haddr2←Haddr1;
  - Hwdata1←Hwdata, Hwdata2←Hwdata1;
  - Hwritereg←Hwrite.
  - When Hreadyin=0, all of these hold.
- **Error FSM states:** ERR_IDLE, ERR_FIRST, ERR_SECOND.
  - ERR_IDLE → ERR_FIRST on an error access; otherwise stay.
  - ERR_FIRST → ERR_SECOND unconditionally.
  - ERR_SECOND → ERR_FIRST if a new error access is presented this cycle; otherwise → ERR_IDLE.
- **FSM outputs (registered state, decoded combinationally):**
  - ERR_IDLE: Hresp=00, Herr_stall=0.
  - ERR_FIRST: Hresp=01, Herr_stall=1.
  - ERR_SECOND: Hresp=01, Herr_stall=0.
- **Write data for errored accesses:** captured in the pipeline but never reaches APB, because valid stayed 0.

## Timing
- **Reset values:** Haddr1/2=0, Hwdata1/2=0, Hwritereg=0, FSM=ERR_IDLE, hence Hresp=00 and Herr_stall=0. valid, tempselx and Hrdata follow their inputs combinationally.
- **Pipeline latency:** Haddr1 lags accepted Haddr by one cycle; Haddr2 by two.
- **valid and tempselx:** zero latency, same cycle as the address phase.
- **Error response:** the error access's address phase is cycle N.
  - Hresp=01 in cycles N+1 and N+2.
  - Herr_stall=1 in N+1 only.
  - Back-to-back errors: Hresp stays 01 continuously, with Herr_stall pulsing every other cycle.
- **Address presented during ERR_FIRST:** valid is forced 0 and the pipeline holds, since Hreadyin is low.
- **Reset mid-error:** reset asserted in any state returns the FSM to ERR_IDLE and OKAY at the next edge.
- **Address arithmetic:** no carry or wrap; decode is pure bit compare. Addresses 0x8BFF_FFFC and 0x8C00_0000 straddle the mapped/unmapped boundary.

## Structure
- **Shared bridge package:**
  - HTRANS_* and HRESP_* constants;
  - error FSM state encoding (2 bits);
  - default BASE_ADDR/SLOT_BITS.
- **Sub-module:** ahb_addr_decode, combinational.
  - Inputs: Haddr, Hsize.
  - Outputs: tempselx, unmapped, misaligned.
  - Reused by the bridge testbench's reference model.
- **Top module keeps:** pipeline registers, qualification logic and error FSM.

## Test plan
- **Reset:** Hresetn=0 for 2 cycles with Haddr=0x8000_0000, Htrans=10 → Haddr1=0, Hresp=00, Herr_stall=0; valid=1 and tempselx=001 combinationally.
- **Write pipeline:** NONSEQ write to 0x8400_0010, Hwdata=0xA5A5_0001, Hreadyin=1 → valid=1, tempselx=010; next cycle Haddr1=0x8400_0010, Hwritereg=1, Hwdata1=0xA5A5_0001; following cycle Haddr2 and Hwdata2 carry the same values.
- **Hold:** Hreadyin=0 for 3 cycles with Haddr changing → Haddr1/Haddr2/Hwdata1 unchanged and valid=0.
- **Unmapped:** NONSEQ read at 0x8C00_0000 → valid=0, tempselx=000; Hresp=01 with Herr_stall=1 in cycle +1, then Hresp=01 with Herr_stall=0 in cycle +2, then OKAY.
- **Misaligned:** Hsize=010 at 0x8800_0002 → same two-cycle ERROR; Hsize=000 at 0x8800_0003 → valid=1, tempselx=100.
- **Qualification:** Htrans=01 (BUSY) and Htrans=00 at 0x8000_0000 → valid=0, no error. Reset asserted in ERR_FIRST → ERR_IDLE and Hresp=00 next cycle.
